// File: rtl/hive_params.sv
// ============================================================================
// Module  : hive_params
// Purpose : Register window layout of the HIVE IRQ controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hive_params;

  localparam logic [2:0] c_reg_en   = 3'd0;
  localparam logic [2:0] c_reg_mode = 3'd1;
  localparam logic [2:0] c_reg_pend = 3'd2;
  localparam logic [2:0] c_reg_insv = 3'd3;
  localparam logic [2:0] c_reg_err  = 3'd4;
  localparam int         c_reg_count = 5;

endpackage

`default_nettype wire

// File: rtl/hive_types.sv
// ============================================================================
// Module  : hive_types
// Purpose : Shared types of the HIVE IRQ controller (thread index, reg offset).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hive_types;

  // Wide enough for the largest supported thread count (16).
  typedef logic [3:0] hive_tid_t;
  typedef logic [2:0] hive_reg_off_t;

endpackage

`default_nettype wire

// File: rtl/hive_irq_sync.sv
// ============================================================================
// Module  : hive_irq_sync
// Purpose : One-bit IRQ request synchronizer with rising-edge detector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hive_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_xsr,
  output logic o_lvl,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_xsr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/hive_irq_ctrl.sv
// ============================================================================
// Module  : hive_irq_ctrl
// Purpose : Round-robin per-thread IRQ controller with rbus register window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hive_irq_ctrl
  import hive_params::*;
  import hive_types::*;
#(
  parameter int THREADS     = 8,
  parameter int ALU_W       = 32,
  parameter int RBUS_ADDR_W = 8,
  parameter int BASE_ADDR   = 'h10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cla_i,
  input  logic [THREADS-1:0]         xsr_i,
  input  logic [RBUS_ADDR_W-1:0]     rbus_addr_i,
  input  logic                       rbus_wr_i,
  input  logic                       rbus_rd_i,
  input  logic [ALU_W-1:0]           rbus_wr_data_i,
  output logic [ALU_W-1:0]           rbus_rd_data_o,
  output logic [$clog2(THREADS)-1:0] id_o,
  output logic                       irq_o,
  output logic [THREADS-1:0]         irq_er_o
);

  localparam int                     ID_W      = $clog2(THREADS);
  localparam logic [ID_W-1:0]        c_id_last = ID_W'(THREADS - 1);
  localparam logic [RBUS_ADDR_W-1:0] c_base    = RBUS_ADDR_W'(BASE_ADDR);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [ID_W-1:0]        r_id;
  logic [THREADS-1:0]     r_en, r_mode, r_pend, r_insv, r_err;
  logic [THREADS-1:0]     w_lvl, w_rise, w_hw_req, w_svc, w_err_set, w_rd_sel;
  logic [THREADS-1:0]     w_wdata;
  logic [RBUS_ADDR_W-1:0] w_off;
  hive_reg_off_t          w_reg;
  logic                   w_hit, w_grant;
  logic [ALU_W-1:0]       r_rd_data;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  for (genvar t = 0; t < THREADS; t++) begin : g_sync
    hive_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk  (clk_i),
      .i_rst_n(w_rst_n),
      .i_xsr  (xsr_i[t]),
      .o_lvl  (w_lvl[t]),
      .o_rise (w_rise[t])
    );
  end

  if (ALU_W > THREADS) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^rbus_wr_data_i[ALU_W-1:THREADS];
  end

  assign w_wdata = rbus_wr_data_i[THREADS-1:0];
  assign w_off   = rbus_addr_i - c_base;
  assign w_hit   = (rbus_addr_i >= c_base) && (w_off < RBUS_ADDR_W'(c_reg_count));
  assign w_reg   = hive_reg_off_t'(w_off);

  always_comb begin
    w_grant = r_pend[r_id] & r_en[r_id] & ~r_insv[r_id] & ~cla_i;
    w_svc   = '0;
    for (int t = 0; t < THREADS; t++) begin
      w_svc[t] = w_grant && (hive_tid_t'(r_id) == hive_tid_t'(t));
    end
    // A level held while in service is the request already being handled.
    w_hw_req  = ((r_mode & w_rise) | (~r_mode & w_lvl & ~r_insv)) & r_en;
    w_err_set = r_mode & w_rise & r_en & r_pend & ~w_svc;
  end

  always_comb begin
    w_rd_sel = '0;
    case (w_reg)
      c_reg_en:   w_rd_sel = r_en;
      c_reg_mode: w_rd_sel = r_mode;
      c_reg_pend: w_rd_sel = r_pend;
      c_reg_insv: w_rd_sel = r_insv;
      c_reg_err:  w_rd_sel = r_err;
      default:    w_rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_id      <= '0;
      r_en      <= '0;
      r_mode    <= '0;
      r_pend    <= '0;
      r_insv    <= '0;
      r_err     <= '0;
      r_rd_data <= '0;
    end else begin
      r_id <= (r_id == c_id_last) ? '0 : r_id + ID_W'(1);
      if (rbus_wr_i && w_hit && w_reg == c_reg_en)   r_en   <= w_wdata;
      if (rbus_wr_i && w_hit && w_reg == c_reg_mode) r_mode <= w_wdata;
      if (cla_i) begin
        r_pend <= '0;
        r_insv <= '0;
        r_err  <= '0;
      end else begin
        // Set terms are OR-ed last so hardware sets beat software clears.
        r_pend <= (r_pend & ~w_svc) | w_hw_req
                | ((rbus_wr_i && w_hit && w_reg == c_reg_pend) ? w_wdata : '0);
        r_insv <= (r_insv & ~((rbus_wr_i && w_hit && w_reg == c_reg_insv) ? w_wdata : '0))
                | w_svc;
        r_err  <= (r_err & ~((rbus_wr_i && w_hit && w_reg == c_reg_err) ? w_wdata : '0))
                | w_err_set;
      end
      r_rd_data <= (rbus_rd_i && w_hit) ? ALU_W'(w_rd_sel) : '0;
    end
  end

  assign id_o           = r_id;
  assign irq_o          = w_grant;
  assign irq_er_o       = r_err;
  assign rbus_rd_data_o = r_rd_data;

endmodule

`default_nettype wire
